// File: rtl/apb_periph_node.sv
// -----------------------------------------------------------------------------
// apb_periph_node
// One-to-many APB bridge. An upstream APB requester is decoded against
// per-slave inclusive address ranges and forwarded to exactly one downstream
// slave. Unmapped accesses get an immediate error response.
//
// Optional feature (macro): APB_NODE_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no pready for TIMEOUT_CYCLES
//   cycles is abandoned and answered with an error response.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   s_paddr/s_pwdata/s_pwrite/
//   s_psel/s_penable              upstream APB request
//   s_prdata/s_pready/s_pslverr   upstream APB response
//   m_paddr/m_pwdata/m_pwrite/
//   m_penable                     downstream request, shared by all slaves
//   m_psel[NB_SLAVE]              one select per slave
//   m_prdata/m_pready/m_pslverr   downstream responses, slave i in slice i
//   start_addr_i/end_addr_i       per-slave inclusive address range
//   err_cnt_o                     saturating count of error responses
// -----------------------------------------------------------------------------
module apb_periph_node #(
   parameter int unsigned NB_SLAVE       = 9,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [APB_ADDR_WIDTH-1:0]          s_paddr,
   input  logic [APB_DATA_WIDTH-1:0]          s_pwdata,
   input  logic                               s_pwrite,
   input  logic                               s_psel,
   input  logic                               s_penable,
   output logic [APB_DATA_WIDTH-1:0]          s_prdata,
   output logic                               s_pready,
   output logic                               s_pslverr,
   output logic [APB_ADDR_WIDTH-1:0]          m_paddr,
   output logic [APB_DATA_WIDTH-1:0]          m_pwdata,
   output logic                               m_pwrite,
   output logic                               m_penable,
   output logic [NB_SLAVE-1:0]                m_psel,
   input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] m_prdata,
   input  logic [NB_SLAVE-1:0]                m_pready,
   input  logic [NB_SLAVE-1:0]                m_pslverr,
   input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i,
   output logic [7:0]                         err_cnt_o
);

   localparam int unsigned AW    = APB_ADDR_WIDTH;
   localparam int unsigned DW    = APB_DATA_WIDTH;
   localparam int unsigned IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
   localparam int unsigned ERR_W = 8;

   // Elaboration-time parameter range checks
   if (NB_SLAVE < 1 || NB_SLAVE > 32) begin : g_bad_nb_slave
      $error("apb_periph_node: NB_SLAVE out of range 1..32");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb_periph_node: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      RESP   = 3'd3,
      ERR    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ERR_W-1:0]  err_q, err_d;

   logic [NB_SLAVE-1:0] m_psel_q, m_psel_d;
   logic                m_penable_q, m_penable_d;
   logic                s_pready_q, s_pready_d;
   logic                s_pslverr_q, s_pslverr_d;
   logic [DW-1:0]       s_prdata_q, s_prdata_d;

   // Response captured on the cycle the FSM leaves ACCESS
   logic [DW-1:0]       rsp_data_c;
   logic                rsp_err_c;

`ifdef APB_NODE_TIMEOUT_EN
   localparam int unsigned TMO_W = 16;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

   // Address decode; the first match while scanning upward wins overlaps
   logic             hit_c;
   logic [IDX_W-1:0] hit_idx_c;

   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int i = 0; i < NB_SLAVE; i++) begin
         if (!hit_c &&
             (s_paddr >= start_addr_i[i*AW +: AW]) &&
             (s_paddr <= end_addr_i[i*AW +: AW])) begin
            hit_c     = 1'b1;
            hit_idx_c = IDX_W'(i);
         end
      end
   end

   // Next-state and next-output logic; outputs are registered from the next state
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      idx_d       = idx_q;
      rsp_data_c  = '0;
      rsp_err_c   = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (s_psel && !s_penable) begin
               addr_d  = s_paddr;
               wdata_d = s_pwdata;
               write_d = s_pwrite;
               idx_d   = hit_idx_c;
               state_d = hit_c ? SETUP : ERR;
            end
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         ACCESS: begin
            // A ready slave takes priority over an expiring timeout
            if (m_pready[idx_q]) begin
               rsp_data_c = m_prdata[idx_q*DW +: DW];
               rsp_err_c  = m_pslverr[idx_q];
               state_d    = RESP;
            end
`ifdef APB_NODE_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_err_c  = 1'b1;
               state_d    = RESP;
            end else begin
               tmo_d      = tmo_q + TMO_W'(1);
            end
`endif
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      m_psel_d    = '0;
      m_penable_d = 1'b0;
      s_pready_d  = 1'b0;
      s_pslverr_d = 1'b0;
      s_prdata_d  = '0;

      unique case (state_d)
         SETUP: begin
            m_psel_d    = NB_SLAVE'(1) << idx_d;
         end
         ACCESS: begin
            m_psel_d    = NB_SLAVE'(1) << idx_d;
            m_penable_d = 1'b1;
         end
         RESP: begin
            s_pready_d  = 1'b1;
            s_pslverr_d = rsp_err_c;
            s_prdata_d  = rsp_data_c;
         end
         ERR: begin
            s_pready_d  = 1'b1;
            s_pslverr_d = 1'b1;
         end
         default: ;
      endcase

      // Each error response counts once; a timeout counts through its error response
      err_d = err_q;
      if (s_pready_d && s_pslverr_d && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         err_q       <= '0;
         m_psel_q    <= '0;
         m_penable_q <= 1'b0;
         s_pready_q  <= 1'b0;
         s_pslverr_q <= 1'b0;
         s_prdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         m_psel_q    <= m_psel_d;
         m_penable_q <= m_penable_d;
         s_pready_q  <= s_pready_d;
         s_pslverr_q <= s_pslverr_d;
         s_prdata_q  <= s_prdata_d;
      end
   end

`ifdef APB_NODE_TIMEOUT_EN
   // ACCESS-phase wait counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign m_paddr   = addr_q;
   assign m_pwdata  = wdata_q;
   assign m_pwrite  = write_q;
   assign m_penable = m_penable_q;
   assign m_psel    = m_psel_q;
   assign s_pready  = s_pready_q;
   assign s_pslverr = s_pslverr_q;
   assign s_prdata  = s_prdata_q;
   assign err_cnt_o = err_q;

endmodule
